// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmitter: the frame state encoding
//   and the default values of the transmitter parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV    = 16;
  localparam int DEF_PARITY_EN  = 0;
  localparam int DEF_PARITY_ODD = 0;
  localparam int DEF_STOP_BITS  = 1;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt
//   Bit-period timer. Counts 0..CLK_DIV-1 and wraps; tick_o marks the last
//   cycle of a bit period. clr_i forces the count back to 0 on the next edge.
//
//   clk_i   in   system clock
//   rstn_i  in   asynchronous active-low reset
//   clr_i   in   restart the count at 0
//   tick_o  out  high while the count equals CLK_DIV-1
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] r_cnt;

  assign tick_o = (r_cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
    end else if (clr_i || tick_o) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx
//   UART transmitter with a valid/ready word input. Frame: one start bit,
//   DATA_WIDTH data bits LSB first, optional parity bit, STOP_BITS stop bits,
//   each bit held for CLK_DIV clocks. A new word may be accepted in the last
//   cycle of the last stop bit, giving gap-free back-to-back frames.
//
//   clk_i      in   system clock
//   rstn_i     in   asynchronous active-low reset
//   rd_vld_i   in   upstream word valid
//   rd_rdy_o   out  word accepted this cycle when rd_vld_i is also high
//   rd_data_i  in   upstream word
//   tx_o       out  serial line, idles high, driven from a register
//   busy_o     out  a frame is in progress
//   done_o     out  pulse in the final cycle of the last stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int PARITY_EN  = DEF_PARITY_EN,
  parameter int PARITY_ODD = DEF_PARITY_ODD,
  parameter int STOP_BITS  = DEF_STOP_BITS
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  rd_vld_i,
  output logic                  rd_rdy_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // Bit index also counts stop bits; DATA_WIDTH >= 5 keeps this >= 3 bits.
  localparam int IDX_W = $clog2(DATA_WIDTH);

  uart_state_t            r_state;
  uart_state_t            w_state_next;
  logic [IDX_W-1:0]       r_bit_idx;
  logic [IDX_W-1:0]       w_bit_idx_next;
  logic [DATA_WIDTH-1:0]  r_shift;
  logic [DATA_WIDTH-1:0]  w_shift_next;
  logic                   r_par;
  logic                   w_par_next;
  logic                   r_tx;
  logic                   w_tx_next;
  logic                   w_tick;
  logic                   w_clr;
  logic                   w_last_stop;
  logic                   w_xfer;

  uart_baud_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (w_clr),
    .tick_o (w_tick)
  );

  // Final cycle of the final stop bit: the only in-frame slot for a handshake.
  assign w_last_stop = (r_state == ST_STOP) && w_tick &&
                       (r_bit_idx == IDX_W'(STOP_BITS - 1));

  assign rd_rdy_o = (r_state == ST_IDLE) || w_last_stop;
  assign w_xfer   = rd_vld_i && rd_rdy_o;
  assign done_o   = w_last_stop;
  assign busy_o   = (r_state != ST_IDLE);
  assign tx_o     = r_tx;

  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_par_next     = r_par;
    w_tx_next      = r_tx;

    // Parity is taken from the whole word at capture, before any shifting.
    if (w_xfer) begin
      w_shift_next = rd_data_i;
      w_par_next   = (^rd_data_i) ^ (PARITY_ODD != 0);
    end

    case (r_state)
      ST_IDLE: begin
        if (w_xfer) w_state_next = ST_START;
      end
      ST_START: begin
        if (w_tick) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
            w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
            w_shift_next   = r_shift >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_bit_idx == IDX_W'(STOP_BITS - 1)) begin
            w_state_next = w_xfer ? ST_START : ST_IDLE;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (w_state_next != r_state) w_bit_idx_next = '0;

    // Line level is computed for the coming cycle so tx_o stays registered.
    case (w_state_next)
      ST_IDLE:   w_tx_next = 1'b1;
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[0];
      ST_PARITY: w_tx_next = w_par_next;
      ST_STOP:   w_tx_next = 1'b1;
      default:   w_tx_next = 1'b1;
    endcase
  end

  // Hold the counter cleared in IDLE and restart it on every state entry.
  assign w_clr = (w_state_next != r_state) || (r_state == ST_IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_par     <= w_par_next;
      r_tx      <= w_tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int CD = 4;
  localparam int DW = 8;
  localparam int NCH = 4;

  // Channel configs: 0 plain, 1 even parity, 2 odd parity, 3 two stop bits.
  int pen   [NCH] = '{0, 1, 1, 0};
  int podd  [NCH] = '{0, 0, 1, 0};
  int nstop [NCH] = '{1, 1, 1, 2};

  logic          clk = 1'b0;
  logic          rstn;
  logic          vld  [NCH];
  logic [DW-1:0] din  [NCH];
  logic          rdy  [NCH];
  logic          tx   [NCH];
  logic          busy [NCH];
  logic          done [NCH];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk_i(clk), .rstn_i(rstn), .rd_vld_i(vld[0]), .rd_rdy_o(rdy[0]), .rd_data_i(din[0]),
    .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]));
  uart_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn), .rd_vld_i(vld[1]), .rd_rdy_o(rdy[1]), .rd_data_i(din[1]),
    .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]));
  uart_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk_i(clk), .rstn_i(rstn), .rd_vld_i(vld[2]), .rd_rdy_o(rdy[2]), .rd_data_i(din[2]),
    .tx_o(tx[2]), .busy_o(busy[2]), .done_o(done[2]));
  uart_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
    .clk_i(clk), .rstn_i(rstn), .rd_vld_i(vld[3]), .rd_rdy_o(rdy[3]), .rd_data_i(din[3]),
    .tx_o(tx[3]), .busy_o(busy[3]), .done_o(done[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int frame_len(input int ch);
    return (1 + DW + pen[ch] + nstop[ch]) * CD;
  endfunction

  // Expected line level in cycle k (1-based) of a frame carrying word w.
  function automatic logic exp_line(input int ch, input logic [DW-1:0] w, input int k);
    int slot;
    slot = (k - 1) / CD;
    if (slot == 0) return 1'b0;
    if (slot <= DW) return w[slot-1];
    if (pen[ch] != 0 && slot == DW + 1) return (^w) ^ (podd[ch] != 0);
    return 1'b1;
  endfunction

  // Called in the handshake cycle; optionally presents the next word in the
  // frame's last cycle so the following call continues back-to-back.
  task automatic send(input int ch, input logic [DW-1:0] w, input bit nxt, input logic [DW-1:0] nw);
    int n;
    int err0;
    n = frame_len(ch);
    err0 = n_err;
    chk($sformatf("ch%0d rdy k=0", ch), rdy[ch], 1);
    vld[ch] = 1'b1;
    din[ch] = w;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      vld[ch] = 1'b0;
      din[ch] = DW'($urandom);
      chk($sformatf("ch%0d tx k=%0d", ch, k), tx[ch], exp_line(ch, w, k));
      chk($sformatf("ch%0d busy k=%0d", ch, k), busy[ch], 1);
      chk($sformatf("ch%0d done k=%0d", ch, k), done[ch], (k == n));
      chk($sformatf("ch%0d rdy k=%0d", ch, k), rdy[ch], (k == n));
      if (k == n && nxt) begin
        vld[ch] = 1'b1;
        din[ch] = nw;
      end
    end
    $display("frame ch%0d data=%02h len=%0d b2b=%0d %s", ch, w, n, nxt, (n_err == err0) ? "ok" : "bad");
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      for (int ch = 0; ch < NCH; ch++) begin
        chk($sformatf("ch%0d idle tx", ch), tx[ch], 1);
        chk($sformatf("ch%0d idle busy", ch), busy[ch], 0);
        chk($sformatf("ch%0d idle done", ch), done[ch], 0);
      end
    end
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] nw;
    bit nb;

    rstn = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      vld[ch] = 1'b0;
      din[ch] = '0;
    end
    #12;
    for (int ch = 0; ch < NCH; ch++) begin
      chk($sformatf("ch%0d rst tx", ch), tx[ch], 1);
      chk($sformatf("ch%0d rst busy", ch), busy[ch], 0);
      chk($sformatf("ch%0d rst done", ch), done[ch], 0);
      chk($sformatf("ch%0d rst rdy", ch), rdy[ch], 1);
    end
    @(posedge clk); #1;
    rstn = 1'b1;

    idle(100);

    // Directed frames.
    send(0, 8'h55, 1'b0, 8'h00);
    idle(2);
    send(0, 8'hA5, 1'b1, 8'h3C);
    send(0, 8'h3C, 1'b0, 8'h00);
    idle(2);
    send(1, 8'h07, 1'b0, 8'h00);
    idle(2);
    send(2, 8'h07, 1'b0, 8'h00);
    idle(2);
    send(3, 8'h00, 1'b0, 8'h00);
    idle(2);

    // Random words with random back-to-back chaining on every configuration.
    for (int ch = 0; ch < NCH; ch++) begin
      w = DW'($urandom);
      for (int i = 0; i < 4; i++) begin
        nw = DW'($urandom);
        nb = (i < 3) ? bit'($urandom_range(0, 1)) : 1'b0;
        send(ch, w, nb, nw);
        if (!nb) idle($urandom_range(1, 3));
        w = nw;
      end
    end

    // Abort a frame with reset in cycle 15, while a data bit drives the line low.
    vld[0] = 1'b1;
    din[0] = 8'h00;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      vld[0] = 1'b0;
      din[0] = DW'($urandom);
    end
    chk("abort tx before rst", tx[0], 0);
    rstn = 1'b0;
    #1;
    chk("abort tx", tx[0], 1);
    chk("abort busy", busy[0], 0);
    chk("abort rdy", rdy[0], 1);
    chk("abort done", done[0], 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    send(0, 8'hFF, 1'b0, 8'h00);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
